// File: rtl/sig_threshold_detector.sv
// sig_threshold_detector
//
// Per-channel crossing detector that sits in front of the scan-cycle controller.
// While armed, it watches the sample stream for a debounced upward crossing of
// `threshold`. On a qualified crossing it emits a one-cycle `detected` pulse and
// reports the timestamp of the first sample of the qualifying run. It then tracks
// the pulse peak until the signal falls back below threshold.
//
// Ports
//   clk           system clock
//   reset         synchronous, active-high reset
//   sync_start    scan sync level; its rising edge restarts the timestamp base
//   enable        arm request from the controller
//   sample_valid  sample_data / threshold are meaningful this cycle
//   sample_data   unsigned ADC sample
//   threshold     detect threshold (unsigned)
//   detected      one-cycle pulse on a qualified crossing
//   edge_time     stamp of the first sample of the qualifying run
//   peak_value    maximum sample between crossing and fall
//   peak_valid    one-cycle pulse when peak_value has been updated
//   busy          high whenever the detector is not idle
module sig_threshold_detector #(
   parameter int unsigned DATA_W   = 12,
   parameter int unsigned CNT_W    = 16,
   parameter int unsigned DEBOUNCE = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              sync_start,
   input  logic              enable,
   input  logic              sample_valid,
   input  logic [DATA_W-1:0] sample_data,
   input  logic [DATA_W-1:0] threshold,
   output logic              detected,
   output logic [CNT_W-1:0]  edge_time,
   output logic [DATA_W-1:0] peak_value,
   output logic              peak_valid,
   output logic              busy
);

   typedef enum logic [2:0] {
      StIdle,
      StArmed,
      StWaitRise,
      StQualify,
      StTrack,
      StDone
   } state_e;

   localparam logic [CNT_W-1:0] CntMax      = '1;
   localparam logic [3:0]       DebounceCnt = 4'(DEBOUNCE);

   state_e              state_q, state_d;
   logic                sync_prev_q;
   logic [CNT_W-1:0]    ts_q, ts_d;
   logic [CNT_W-1:0]    cand_time_q, cand_time_d;
   logic [3:0]          run_cnt_q, run_cnt_d;
   logic [DATA_W-1:0]   peak_q, peak_d;
   logic [CNT_W-1:0]    edge_time_q, edge_time_d;
   logic [DATA_W-1:0]   peak_value_q, peak_value_d;
   logic                detected_q, detected_d;
   logic                peak_valid_q, peak_valid_d;

   logic                sync_rise;
   logic                above;
   logic                below;
   logic [CNT_W-1:0]    stamp;
   logic [DATA_W-1:0]   peak_max;
   logic [3:0]          run_inc;

   always_comb begin
      sync_rise = sync_start & ~sync_prev_q;
      above     = sample_valid & (sample_data >= threshold);
      below     = sample_valid & (sample_data < threshold);
      // A sample coincident with the sync edge is the first of the new base.
      stamp     = sync_rise ? '0 : ts_q;
      peak_max  = (sample_data > peak_q) ? sample_data : peak_q;
      run_inc   = run_cnt_q + 4'd1;
   end

   // Timestamp counter: counts valid beats since the last sync edge, saturating.
   always_comb begin
      ts_d = ts_q;
      if (sync_rise) begin
         ts_d = sample_valid ? {{(CNT_W-1){1'b0}}, 1'b1} : '0;
      end else if (sample_valid && (ts_q != CntMax)) begin
         ts_d = ts_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

   always_comb begin
      state_d      = state_q;
      cand_time_d  = cand_time_q;
      run_cnt_d    = run_cnt_q;
      peak_d       = peak_q;
      edge_time_d  = edge_time_q;
      peak_value_d = peak_value_q;
      detected_d   = 1'b0;
      peak_valid_d = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (enable) begin
               state_d = StArmed;
            end
         end

         // Wait for a below-threshold baseline so an already-high channel is
         // not reported as a fresh crossing.
         StArmed: begin
            if (sync_rise || !enable) begin
               state_d   = StIdle;
               run_cnt_d = '0;
               peak_d    = '0;
            end else if (below) begin
               state_d = StWaitRise;
            end
         end

         StWaitRise: begin
            if (sync_rise || !enable) begin
               state_d   = StIdle;
               run_cnt_d = '0;
               peak_d    = '0;
            end else if (above) begin
               cand_time_d = stamp;
               run_cnt_d   = 4'd1;
               peak_d      = sample_data;
               if (DEBOUNCE == 1) begin
                  detected_d  = 1'b1;
                  edge_time_d = stamp;
                  state_d     = StTrack;
               end else begin
                  state_d = StQualify;
               end
            end
         end

         StQualify: begin
            if (sync_rise || !enable) begin
               state_d   = StIdle;
               run_cnt_d = '0;
               peak_d    = '0;
            end else if (above) begin
               run_cnt_d = run_inc;
               peak_d    = peak_max;
               if (run_inc == DebounceCnt) begin
                  detected_d  = 1'b1;
                  edge_time_d = cand_time_q;
                  state_d     = StTrack;
               end
            end else if (below) begin
               // Glitch: drop the candidate and look for a new rise.
               state_d   = StWaitRise;
               run_cnt_d = '0;
               peak_d    = '0;
            end
         end

         // Enable low here does not abort: the fall is still reported.
         StTrack: begin
            if (sync_rise) begin
               state_d   = StIdle;
               run_cnt_d = '0;
               peak_d    = '0;
            end else if (above) begin
               peak_d = peak_max;
            end else if (below) begin
               peak_value_d = peak_q;
               peak_valid_d = 1'b1;
               state_d      = enable ? StDone : StIdle;
            end
         end

         StDone: begin
            if (!enable) begin
               state_d = StIdle;
            end
         end

         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= StIdle;
         sync_prev_q  <= 1'b0;
         ts_q         <= '0;
         cand_time_q  <= '0;
         run_cnt_q    <= '0;
         peak_q       <= '0;
         edge_time_q  <= '0;
         peak_value_q <= '0;
         detected_q   <= 1'b0;
         peak_valid_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         sync_prev_q  <= sync_start;
         ts_q         <= ts_d;
         cand_time_q  <= cand_time_d;
         run_cnt_q    <= run_cnt_d;
         peak_q       <= peak_d;
         edge_time_q  <= edge_time_d;
         peak_value_q <= peak_value_d;
         detected_q   <= detected_d;
         peak_valid_q <= peak_valid_d;
      end
   end

   assign detected   = detected_q;
   assign edge_time  = edge_time_q;
   assign peak_value = peak_value_q;
   assign peak_valid = peak_valid_q;
   assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_sig_threshold_detector.sv
module tb_sig_threshold_detector;

   logic        clk = 1'b0;
   logic        reset;
   logic        sync_start;
   logic        enable;
   logic        sample_valid;
   logic [11:0] sample_data;
   logic [11:0] threshold;

   logic        detected, peak_valid, busy;
   logic [15:0] edge_time;
   logic [11:0] peak_value;

   logic        s_detected, s_peak_valid, s_busy;
   logic [3:0]  s_edge_time;
   logic [11:0] s_peak_value;

   always #5 clk = ~clk;

   sig_threshold_detector #(.DATA_W(12), .CNT_W(16), .DEBOUNCE(4)) u_dut (
      .clk          (clk),
      .reset        (reset),
      .sync_start   (sync_start),
      .enable       (enable),
      .sample_valid (sample_valid),
      .sample_data  (sample_data),
      .threshold    (threshold),
      .detected     (detected),
      .edge_time    (edge_time),
      .peak_value   (peak_value),
      .peak_valid   (peak_valid),
      .busy         (busy)
   );

   // Narrow timestamp instance for the saturation case; shares all stimulus.
   sig_threshold_detector #(.DATA_W(12), .CNT_W(4), .DEBOUNCE(4)) u_sat (
      .clk          (clk),
      .reset        (reset),
      .sync_start   (sync_start),
      .enable       (enable),
      .sample_valid (sample_valid),
      .sample_data  (sample_data),
      .threshold    (threshold),
      .detected     (s_detected),
      .edge_time    (s_edge_time),
      .peak_value   (s_peak_value),
      .peak_valid   (s_peak_valid),
      .busy         (s_busy)
   );

   typedef struct {
      bit rst; bit en; bit sy; bit v; int d; int th;
      bit det; bit pv; bit bsy; int ex_edge; int ex_peak;
   } vec_t;

   vec_t tbl[$];
   vec_t exp_q[$];
   int   th_c   = 100;
   int   edge_c = 0;
   int   peak_c = 0;
   int   n_vec  = 0;
   int   n_chk  = 0;
   int   n_err  = 0;

   function automatic void add(bit rst, bit en, bit sy, bit v, int d, bit bsy,
                               bit det, bit pv);
      vec_t r;
      r.rst = rst; r.en = en; r.sy = sy; r.v = v; r.d = d; r.th = th_c;
      r.det = det; r.pv = pv; r.bsy = bsy; r.ex_edge = edge_c; r.ex_peak = peak_c;
      tbl.push_back(r);
   endfunction

   function automatic void vec(bit en, bit sy, bit v, int d, bit bsy,
                               bit det = 1'b0, bit pv = 1'b0);
      add(1'b0, en, sy, v, d, bsy, det, pv);
   endfunction

   function automatic void rstv();
      edge_c = 0;
      peak_c = 0;
      add(1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
   endfunction

   // Sync rise while idle (counter to 0), then arm.
   function automatic void resync();
      vec(0, 0, 0, 0, 0);
      vec(0, 1, 0, 0, 0);
      vec(1, 1, 0, 0, 1);
   endfunction

   task automatic check(string name, int idx, int act, int exp);
      n_chk++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s vec %0d: got %0d, expected %0d", name, idx, act, exp);
      end
   endtask

   task automatic run_table();
      vec_t r;
      vec_t e;
      int   sat_edge;
      for (int i = 0; i < tbl.size(); i++) begin
         r = tbl[i];
         @(negedge clk);
         reset        = r.rst;
         enable       = r.en;
         sync_start   = r.sy;
         sample_valid = r.v;
         sample_data  = 12'(r.d);
         threshold    = 12'(r.th);
         exp_q.push_back(r);
         n_vec++;
         @(posedge clk);
         #1;
         e = exp_q.pop_front();
         sat_edge = (e.ex_edge > 15) ? 15 : e.ex_edge;
         check("detected",   n_vec, int'(detected),     int'(e.det));
         check("peak_valid", n_vec, int'(peak_valid),   int'(e.pv));
         check("busy",       n_vec, int'(busy),         int'(e.bsy));
         check("edge_time",  n_vec, int'(edge_time),    e.ex_edge);
         check("peak_value", n_vec, int'(peak_value),   e.ex_peak);
         check("sat_det",    n_vec, int'(s_detected),   int'(e.det));
         check("sat_edge",   n_vec, int'(s_edge_time),  sat_edge);
      end
      tbl.delete();
   endtask

   initial begin
      reset = 1'b1; enable = 1'b0; sync_start = 1'b0; sample_valid = 1'b0;
      sample_data = '0; threshold = 12'd100;

      // Basic crossing: 50,50,120,130,140,150,90
      rstv();
      resync();
      vec(1, 1, 1, 50, 1);
      vec(1, 1, 1, 50, 1);
      vec(1, 1, 1, 120, 1);
      vec(1, 1, 1, 130, 1);
      vec(1, 1, 1, 140, 1);
      edge_c = 2;
      vec(1, 1, 1, 150, 1, 1, 0);
      peak_c = 150;
      vec(1, 1, 1, 90, 1, 0, 1);
      vec(1, 1, 0, 0, 1);
      vec(0, 1, 0, 0, 0);

      // Glitch rejection
      resync();
      vec(1, 1, 1, 50, 1);
      vec(1, 1, 1, 120, 1);
      vec(1, 1, 1, 130, 1);
      vec(1, 1, 1, 60, 1);
      vec(1, 1, 1, 120, 1);
      vec(1, 1, 1, 121, 1);
      vec(1, 1, 1, 122, 1);
      edge_c = 4;
      vec(1, 1, 1, 123, 1, 1, 0);
      peak_c = 123;
      vec(1, 1, 1, 40, 1, 0, 1);
      vec(0, 1, 0, 0, 0);

      // Already high when armed: needs a baseline first
      resync();
      for (int i = 0; i < 10; i++) vec(1, 1, 1, 200, 1);
      vec(1, 1, 1, 50, 1);
      vec(1, 1, 1, 200, 1);
      vec(1, 1, 1, 200, 1);
      vec(1, 1, 1, 200, 1);
      edge_c = 11;
      vec(1, 1, 1, 200, 1, 1, 0);
      peak_c = 200;
      vec(1, 1, 1, 10, 1, 0, 1);
      vec(0, 1, 0, 0, 0);

      // Enable dropped in QUALIFY, then re-armed behaves as ARMED
      resync();
      vec(1, 1, 1, 50, 1);
      vec(1, 1, 1, 120, 1);
      vec(1, 1, 1, 130, 1);
      vec(0, 1, 1, 140, 0);
      vec(1, 1, 0, 0, 1);
      for (int i = 0; i < 5; i++) vec(1, 1, 1, 200, 1);
      vec(1, 1, 1, 50, 1);
      vec(0, 1, 0, 0, 0);

      // Invalid beats interleaved with a qualifying run
      resync();
      vec(1, 1, 1, 50, 1);
      vec(1, 1, 0, 0, 1);
      vec(1, 1, 0, 3000, 1);
      vec(1, 1, 1, 120, 1);
      vec(1, 1, 0, 0, 1);
      vec(1, 1, 1, 130, 1);
      vec(1, 1, 0, 5, 1);
      vec(1, 1, 1, 140, 1);
      vec(1, 1, 0, 0, 1);
      edge_c = 1;
      vec(1, 1, 1, 150, 1, 1, 0);
      vec(1, 1, 0, 0, 1);
      peak_c = 150;
      vec(1, 1, 1, 20, 1, 0, 1);
      vec(0, 1, 0, 0, 0);

      // Timestamp saturation (u_sat reports 15)
      resync();
      for (int i = 0; i < 20; i++) vec(1, 1, 1, 50, 1);
      vec(1, 1, 1, 200, 1);
      vec(1, 1, 1, 200, 1);
      vec(1, 1, 1, 200, 1);
      edge_c = 20;
      vec(1, 1, 1, 200, 1, 1, 0);
      peak_c = 200;
      vec(1, 1, 1, 10, 1, 0, 1);
      vec(0, 1, 0, 0, 0);

      // Sync rise with a valid sample: that sample is stamp 0
      vec(0, 0, 0, 0, 0);
      vec(0, 1, 1, 0, 0);
      vec(1, 1, 0, 0, 1);
      vec(1, 1, 1, 50, 1);
      vec(1, 1, 1, 200, 1);
      vec(1, 1, 1, 220, 1);
      vec(1, 1, 1, 210, 1);
      edge_c = 2;
      vec(1, 1, 1, 205, 1, 1, 0);
      peak_c = 220;
      vec(1, 1, 1, 10, 1, 0, 1);
      vec(0, 1, 0, 0, 0);

      // Sync rise aborts QUALIFY
      resync();
      vec(1, 1, 1, 50, 1);
      vec(1, 1, 1, 120, 1);
      vec(1, 0, 1, 130, 1);
      vec(1, 1, 1, 140, 0);
      vec(1, 1, 0, 0, 1);
      vec(0, 1, 0, 0, 0);

      // Threshold raised mid-qualification
      resync();
      vec(1, 1, 1, 50, 1);
      vec(1, 1, 1, 120, 1);
      vec(1, 1, 1, 130, 1);
      th_c = 150;
      vec(1, 1, 1, 130, 1);
      vec(1, 1, 1, 160, 1);
      vec(1, 1, 1, 160, 1);
      vec(1, 1, 1, 160, 1);
      edge_c = 4;
      vec(1, 1, 1, 160, 1, 1, 0);
      peak_c = 160;
      vec(1, 1, 1, 140, 1, 0, 1);
      vec(0, 1, 0, 0, 0);
      th_c = 100;
      run_table();

      // Hand-written: reset while tracking clears everything, no pending pulse
      resync();
      vec(1, 1, 1, 50, 1);
      vec(1, 1, 1, 200, 1);
      vec(1, 1, 1, 200, 1);
      vec(1, 1, 1, 200, 1);
      edge_c = 1;
      vec(1, 1, 1, 200, 1, 1, 0);
      vec(1, 1, 1, 230, 1);
      rstv();
      vec(1, 1, 1, 10, 1);
      vec(1, 1, 1, 20, 1);
      vec(0, 1, 0, 0, 0);
      run_table();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/sig_threshold_detector.md
Name: sig_threshold_detector

Overview:
- Upstream of the scan-cycle controller; one instance per channel (L and R).
- While its enable input is high, it watches the channel's sample stream for a debounced upward threshold crossing.
- On a qualified crossing it emits a one-cycle detect pulse, which drives the controller's sig_l_detected / sig_r_detected input.
- It also reports the crossing timestamp in samples since the last sync edge, and the peak amplitude of the pulse.

Parameters:
- DATA_W, 12, sample and threshold width (unsigned).
- CNT_W, 16, timestamp counter width.
- DEBOUNCE, 4, consecutive above-threshold valid samples required to qualify (1..15).

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- sync_start  input  1  scan sync level; its rising edge restarts the timestamp.
- enable  input  1  arm request from the controller (sig_x_enable).
- sample_valid  input  1  sample_data is valid this cycle.
- sample_data  input  DATA_W  unsigned ADC sample.
- threshold  input  DATA_W  detect threshold; sampled only on valid beats.
- detected  output  1  one-cycle pulse on a qualified crossing.
- edge_time  output  CNT_W  timestamp of the first sample of the qualifying run.
- peak_value  output  DATA_W  maximum sample between crossing and fall.
- peak_valid  output  1  one-cycle pulse when peak_value is final.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset: state=IDLE; detected=0, peak_valid=0, busy=0, edge_time=0, peak_value=0, timestamp counter=0, internal sync_prev=0.
- Sync edge: sync_rise = sync_start & ~sync_prev, with sync_prev registered every cycle.
- Timestamp counter:
  - On sync_rise the counter loads 1 if sample_valid else 0; a coincident valid sample takes stamp 0.
  - Otherwise it increments on each sample_valid.
  - It saturates at 2^CNT_W-1 and never wraps.
- "above" means sample_data >= threshold, evaluated only when sample_valid=1. Invalid cycles change no FSM state or counters except as noted.
- IDLE: when enable=1, go to ARMED. detected stays 0.
- ARMED: requires a baseline first, so a channel already above threshold is not falsely detected.
  - A valid sample not above goes to WAIT_RISE.
  - A valid sample above stays in ARMED.
- WAIT_RISE: a valid above sample latches cand_time=timestamp of that sample and run_cnt=1, and latches peak=sample.
  - If DEBOUNCE=1, go straight to the detect action.
  - Otherwise go to QUALIFY.
- QUALIFY:
  - A valid above sample increments run_cnt and updates peak=max(peak,sample).
  - When run_cnt reaches DEBOUNCE: detected=1 for exactly the next cycle, edge_time<=cand_time, and go to TRACK.
  - A valid not-above sample returns to WAIT_RISE, discarding cand_time and peak.
- TRACK: peak=max(peak,sample) on each valid above sample.
  - The first valid not-above sample sets peak_value<=peak and peak_valid=1 for one cycle, then goes to DONE.
- DONE: hold outputs; when enable=0, go to IDLE.
- Latency: detected asserts the cycle after the clock edge that samples the DEBOUNCE-th qualifying sample. peak_valid follows the same rule for the falling sample.
- enable low in ARMED, WAIT_RISE or QUALIFY: go to IDLE next cycle; no detected pulse; run_cnt and peak are cleared.
- enable low in TRACK: peak_valid is still produced on the fall, then go to IDLE. busy stays high until then.
- sync_rise in any state other than IDLE and DONE aborts to IDLE. The controller re-arms via enable; a stale detect is never reported against a new timestamp base.
- edge_time and peak_value hold their values until overwritten by the next detection; they are not cleared by sync.
- Threshold changes mid-qualification take effect on the next valid sample.
- Reset asserted mid-operation returns everything to reset values on the next edge; there are no pending pulses.

Test Plan:
- DEBOUNCE=4, threshold=100, sync rise then samples 50,50,120,130,140,150,90 on consecutive valid beats → detected pulses one cycle after sample 150; edge_time=2; peak_valid follows sample 90 with peak_value=150.
- Glitch rejection: samples 50,120,130,60,120,121,122,123,40 → one detected only, edge_time=4; peak_value=123.
- Pre-existing high: enable rises while samples stay at 200 for 10 beats, then 50, then 4×200 → no detect during the first 10 beats; detect with edge_time equal to the stamp of the first 200 after the 50.
- Enable dropped during QUALIFY after 2 above samples → no detected, busy=0 the next cycle, and the state returns to ARMED behaviour on re-enable.
- sample_valid toggled 1-0-1-0 during a qualifying run → invalid cycles ignored; the run completes after 4 valid beats and edge_time counts only valid beats.
- CNT_W=4: 20 valid beats before the crossing → edge_time=15 (saturated). A sync rise coincident with a valid sample gives that sample stamp 0.
